// File: rtl/memory_instr_decoder.sv
// Memory-side instruction decoder: line buffer, address register, BRAM and FMA write bus.
// Optional MEMDEC_DROP_COUNT_EN adds a saturating count of stalled valid cycles.
module memory_instr_decoder #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  localparam int LW = 3 * FMA_COUNT * WORD_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [0:31]           instr_in,
  input  logic                  instr_valid_in,
  output logic                  ready_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [LW-1:0]         bram_din_out,
  output logic                  bram_we_out,
  input  logic [LW-1:0]         bram_dout_in,
  output logic [LW-1:0]         fma_line_out,
  output logic                  fma_replace_c_out,
  output logic                  fma_result_valid_out,
`ifdef MEMDEC_DROP_COUNT_EN
  output logic [7:0]            drop_count_out,
`endif
  output logic                  fma_write_valid_out
);

  typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;

  localparam logic [3:0] OP_SMA    = 4'b0110;
  localparam logic [3:0] OP_LOADI  = 4'b0111;
  localparam logic [3:0] OP_SENDL  = 4'b1000;
  localparam logic [3:0] OP_LOAD   = 4'b1010;
  localparam logic [3:0] OP_WRITEB = 4'b1011;
  localparam logic [3:0] OP_WRITE  = 4'b1100;

  state_t state, state_nx;

  logic [3:0]            op, fa, fb;
  logic [15:0]           imm, step;
  logic [7:0]            diff;
  logic                  take;
  logic [LW-1:0]         line, line_nx, fma_line_q;
  logic [ADDR_WIDTH-1:0] maddr;
  logic                  wb_hit, pend_rc, pend_rv;

  assign op   = instr_in[0:3];
  assign fa   = instr_in[4:7];
  assign imm  = instr_in[8:23];
  assign fb   = instr_in[24:27];
  assign diff = instr_in[24:31];
  assign step = {{8{diff[7]}}, diff};

  assign ready_out = (state == IDLE);
  assign take      = instr_valid_in & ready_out;

  // Read data arrives combinationally in the strobe cycle, then is held.
  assign fma_line_out = wb_hit ? bram_dout_in : fma_line_q;

  always_comb begin
    state_nx = state;
    line_nx  = line;
    unique case (state)
      IDLE:    if (take && op == OP_WRITEB) state_nx = RD1;
      RD1:     state_nx = RD2;
      RD2:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (take) begin
      case (op)
        OP_LOADI:
          if (int'(fa) < 3 * FMA_COUNT)
            line_nx[int'(fa)*WORD_WIDTH +: WORD_WIDTH] = imm;
        OP_LOAD:
          if (fa <= 4'd2)
            for (int i = 0; i < FMA_COUNT; i++)
              line_nx[(3*i+int'(fa))*WORD_WIDTH +: WORD_WIDTH] =
                imm + 16'(i) * step;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                <= IDLE;
      line                 <= '0;
      maddr                <= '0;
      bram_addr_out        <= '0;
      bram_din_out         <= '0;
      bram_we_out          <= 1'b0;
      fma_line_q           <= '0;
      fma_replace_c_out    <= 1'b0;
      fma_result_valid_out <= 1'b0;
      fma_write_valid_out  <= 1'b0;
      wb_hit               <= 1'b0;
      pend_rc              <= 1'b0;
      pend_rv              <= 1'b0;
    end else begin
      state               <= state_nx;
      line                <= line_nx;
      bram_we_out         <= take && op == OP_SENDL;
      fma_write_valid_out <= (take && op == OP_WRITE) || state == RD2;
      wb_hit              <= (state == RD2);
      if (wb_hit) fma_line_q <= bram_dout_in;
      if (take && op == OP_SMA) maddr <= imm[ADDR_WIDTH-1:0];
      if (take && op == OP_SENDL) begin
        bram_addr_out <= maddr;
        bram_din_out  <= line;
      end
      if (take && op == OP_WRITEB) begin
        bram_addr_out <= imm[ADDR_WIDTH-1:0];
        pend_rc       <= (fa != 4'd0);
        pend_rv       <= (fb != 4'd0);
      end
      if (take && op == OP_WRITE) begin
        fma_line_q           <= line;
        fma_replace_c_out    <= (fa != 4'd0);
        fma_result_valid_out <= (fb != 4'd0);
      end else if (state == RD2) begin
        fma_replace_c_out    <= pend_rc;
        fma_result_valid_out <= pend_rv;
      end
    end
  end

`ifdef MEMDEC_DROP_COUNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) drop_count_out <= '0;
    else if (instr_valid_in && !ready_out && drop_count_out != 8'hFF)
      drop_count_out <= drop_count_out + 8'd1;
  end
`endif

endmodule

// File: tb/tb_memory_instr_decoder.sv
// Directed bench for memory_instr_decoder with a 2-cycle-latency BRAM model.
// Optional MEMDEC_DROP_COUNT_EN checks are compiled in with the macro.
module tb_memory_instr_decoder;
  localparam int LW = 96;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:31]   instr;
  logic          valid;
  logic          ready;
  logic [11:0]   baddr;
  logic [LW-1:0] bdin, bdout, fline, d1;
  logic          bwe, rc, rv, wv;
`ifdef MEMDEC_DROP_COUNT_EN
  logic [7:0]    drops;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [LW-1:0] EXP1 = 96'hBEEF_0000_0000_0000_0000_1234;
  localparam logic [LW-1:0] EXP2 = 96'hBEEF_00FE_0000_0000_0100_1234;
  localparam logic [LW-1:0] PAT  = {12{8'hA5}};
  localparam logic [LW-1:0] P020 = {6{16'h0020}};

  memory_instr_decoder dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .instr_in             (instr),
    .instr_valid_in       (valid),
    .ready_out            (ready),
    .bram_addr_out        (baddr),
    .bram_din_out         (bdin),
    .bram_we_out          (bwe),
    .bram_dout_in         (bdout),
    .fma_line_out         (fline),
    .fma_replace_c_out    (rc),
    .fma_result_valid_out (rv),
`ifdef MEMDEC_DROP_COUNT_EN
    .drop_count_out       (drops),
`endif
    .fma_write_valid_out  (wv)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] mem(input logic [11:0] a);
    if (a == 12'h010) return PAT;
    return {6{4'h0, a}};
  endfunction

  always @(posedge clk) begin
    d1    <= mem(baddr);
    bdout <= d1;
  end

  function automatic logic [0:31] mk(input logic [3:0] op, input logic [3:0] a,
                                     input logic [15:0] imm, input logic [7:0] bc);
    return {op, a, imm, bc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    instr = '0;
    #12;
    check("rst_ready", LW'(ready), 1);
    check("rst_we",    LW'(bwe),   0);
    check("rst_wv",    LW'(wv),    0);
    check("rst_addr",  LW'(baddr), 0);
    check("rst_din",   bdin,       0);
    check("rst_line",  fline,      0);
    check("rst_rc_rv", LW'({rc, rv}), 0);
`ifdef MEMDEC_DROP_COUNT_EN
    check("rst_drop",  LW'(drops), 0);
`endif
    #3 rst_n = 1'b1;
    tick();

    // SMA, LOADI x2, SENDL back to back
    valid = 1'b1;
    instr = mk(4'b0110, 4'd0, 16'h0005, 8'h00); tick();
    check("t1_ready", LW'(ready), 1);
    instr = mk(4'b0111, 4'd0, 16'h1234, 8'h00); tick();
    instr = mk(4'b0111, 4'd5, 16'hBEEF, 8'h00); tick();
    instr = mk(4'b1000, 4'd0, 16'h0000, 8'h00); tick();
    valid = 1'b0;
    check("t1_we",   LW'(bwe),   1);
    check("t1_addr", LW'(baddr), 12'h005);
    check("t1_din",  bdin,       EXP1);
    check("t1_wv",   LW'(wv),    0);
    tick();
    check("t1_we_off", LW'(bwe), 0);

    // LOAD with negative stride, then WRITE
    valid = 1'b1;
    instr = mk(4'b1010, 4'd1, 16'h0100, 8'hFE); tick();
    instr = mk(4'b1100, 4'd1, 16'h0000, 8'h00); tick();
    valid = 1'b0;
    check("t2_wv",   LW'(wv),  1);
    check("t2_line", fline,    EXP2);
    check("t2_rc",   LW'(rc),  1);
    check("t2_rv",   LW'(rv),  0);
    check("t2_we",   LW'(bwe), 0);
    tick();
    check("t2_wv_off", LW'(wv), 0);
    check("t2_hold",   fline,   EXP2);

    // WRITEB from 0x010
    valid = 1'b1;
    instr = mk(4'b1011, 4'd0, 16'h0010, 8'h10);
    check("t3_readyT", LW'(ready), 1);
    tick();
    valid = 1'b0;
    check("t3_ready1", LW'(ready), 0);
    check("t3_addr",   LW'(baddr), 12'h010);
    check("t3_wv1",    LW'(wv),    0);
    tick();
    check("t3_ready2", LW'(ready), 0);
    check("t3_wv2",    LW'(wv),    0);
    tick();
    check("t3_ready3", LW'(ready), 1);
    check("t3_wv3",    LW'(wv),    1);
    check("t3_line",   fline,      PAT);
    check("t3_rv",     LW'(rv),    1);
    check("t3_rc",     LW'(rc),    0);
    tick();
    check("t3_wv_off", LW'(wv), 0);
    check("t3_hold",   fline,   PAT);

    // WRITEB from 0x020 with SENDL held during busy
    valid = 1'b1;
    instr = mk(4'b1011, 4'd1, 16'h0020, 8'h00); tick();
    instr = mk(4'b1000, 4'd0, 16'h0000, 8'h00);
    check("t4_ready1", LW'(ready), 0);
    check("t4_we1",    LW'(bwe),   0);
    tick();
    check("t4_ready2", LW'(ready), 0);
    check("t4_we2",    LW'(bwe),   0);
    tick();
    check("t4_ready3", LW'(ready), 1);
    check("t4_wv3",    LW'(wv),    1);
    check("t4_we3",    LW'(bwe),   0);
    check("t4_line",   fline,      P020);
    check("t4_rc",     LW'(rc),    1);
    check("t4_rv",     LW'(rv),    0);
    tick();
    valid = 1'b0;
    check("t4_we4",   LW'(bwe),   1);
    check("t4_addr4", LW'(baddr), 12'h005);
    check("t4_din4",  bdin,       EXP2);
    check("t4_wv4",   LW'(wv),    0);
`ifdef MEMDEC_DROP_COUNT_EN
    check("t4_drop",  LW'(drops), 2);
`endif
    tick();
    check("t4_we_off", LW'(bwe), 0);

    // Out-of-range LOADI and LOAD leave the line untouched
    valid = 1'b1;
    instr = mk(4'b0111, 4'd6, 16'hDEAD, 8'h00); tick();
    instr = mk(4'b1010, 4'd3, 16'h7777, 8'h01); tick();
    instr = mk(4'b1100, 4'd0, 16'h0000, 8'h10); tick();
    valid = 1'b0;
    check("t5_wv",   LW'(wv), 1);
    check("t5_line", fline,   EXP2);
    check("t5_rc",   LW'(rc), 0);
    check("t5_rv",   LW'(rv), 1);

    // Reset in T+1 of a WRITEB
    tick();
    valid = 1'b1;
    instr = mk(4'b1011, 4'd1, 16'h0010, 8'h10); tick();
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_ready_rst", LW'(ready), 1);
    check("t6_addr_rst",  LW'(baddr), 0);
    check("t6_wv_rst",    LW'(wv),    0);
    #2 rst_n = 1'b1;
    tick();
    check("t6_wv2",    LW'(wv),    0);
    check("t6_ready2", LW'(ready), 1);
    tick();
    check("t6_wv3", LW'(wv), 0);
    valid = 1'b1;
    instr = mk(4'b1000, 4'd0, 16'h0000, 8'h00); tick();
    valid = 1'b0;
    check("t6_we",   LW'(bwe),   1);
    check("t6_addr", LW'(baddr), 0);
    check("t6_din",  bdin,       0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
